// File: rtl/intr_ctrl.sv
// intr_ctrl: per-channel interrupt latching with edge/level detect, mask,
// software set/clear, lowest-channel ID encode and a stretched CPU pulse.
module intr_ctrl #(
    parameter int unsigned NUM_INTR  = 4,
    parameter int unsigned PULSE_LEN = 1,
    localparam int unsigned ID_W     = (NUM_INTR > 1) ? $clog2(NUM_INTR) : 1
) (
    input  logic                clk,
    input  logic                reset_n_i,
    input  logic [NUM_INTR-1:0] intr_signal_i,
    input  logic [NUM_INTR-1:0] intr_mode_i,
    input  logic [NUM_INTR-1:0] intr_mask_i,
    input  logic [NUM_INTR-1:0] intr_set_i,
    input  logic [NUM_INTR-1:0] intr_clear_i,
    output logic [NUM_INTR-1:0] intr_status_o,
    output logic                intr_pending_o,
    output logic [ID_W-1:0]     intr_id_o,
    output logic                bus_intr_o
);

    localparam int unsigned CNT_W = 4;

    logic [NUM_INTR-1:0] sig_prev_q;
    logic [NUM_INTR-1:0] event_c;
    logic [NUM_INTR-1:0] req_c;
    logic [NUM_INTR-1:0] status_d;
    logic [NUM_INTR-1:0] active_c;
    logic                trig_c;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                bus_d;

    // Event detect, status update and pulse-counter next state.
    always_comb begin
        event_c  = '0;
        req_c    = '0;
        status_d = intr_status_o;
        trig_c   = 1'b0;
        cnt_d    = cnt_q;
        bus_d    = 1'b0;

        for (int n = 0; n < NUM_INTR; n++) begin
            event_c[n] = intr_mode_i[n] ? (intr_signal_i[n] & ~sig_prev_q[n])
                                        : intr_signal_i[n];
        end
        req_c    = event_c | intr_set_i;
        status_d = (intr_status_o | req_c) & ~intr_clear_i;
        // Only a fresh, enabled, not-simultaneously-cleared request fires the pulse.
        trig_c   = |(req_c & intr_mask_i & ~intr_status_o & ~intr_clear_i);

        if (trig_c) begin
            cnt_d = CNT_W'(PULSE_LEN);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        bus_d = (cnt_d != '0);
    end

    // State registers; reset clears everything including an in-flight pulse.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sig_prev_q    <= '0;
            intr_status_o <= '0;
            cnt_q         <= '0;
            bus_intr_o    <= 1'b0;
        end else begin
            sig_prev_q    <= intr_signal_i;
            intr_status_o <= status_d;
            cnt_q         <= cnt_d;
            bus_intr_o    <= bus_d;
        end
    end

    // Pending flag and lowest-numbered active channel from registered status.
    always_comb begin
        active_c       = intr_status_o & intr_mask_i;
        intr_pending_o = |active_c;
        intr_id_o      = '0;
        for (int i = NUM_INTR - 1; i >= 0; i--) begin
            if (active_c[i]) begin
                intr_id_o = ID_W'(i);
            end
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed vectors with a queue scoreboard for two 4-channel
// instances (pulse length 3 and 1) and direct reset checks on a 16-channel one.
module tb_intr_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sig, mode, mask, set, clr;
    logic [3:0] st_a, st_b;
    logic       pend_a, pend_b, bus_a, bus_b;
    logic [1:0] id_a, id_b;

    logic        rst_w_n;
    logic [15:0] sig_w, set_w, st_w;
    logic        pend_w, bus_w;
    logic [3:0]  id_w;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] st;
        logic       ba;
        logic       bb;
        logic       pend;
        logic [1:0] id;
    } exp_t;

    exp_t  sb[$];
    string sb_nm[$];

    always #5 clk = ~clk;

    intr_ctrl #(.NUM_INTR(4), .PULSE_LEN(3)) u_a (
        .clk(clk), .reset_n_i(rst_n), .intr_signal_i(sig), .intr_mode_i(mode),
        .intr_mask_i(mask), .intr_set_i(set), .intr_clear_i(clr),
        .intr_status_o(st_a), .intr_pending_o(pend_a), .intr_id_o(id_a),
        .bus_intr_o(bus_a));

    intr_ctrl #(.NUM_INTR(4), .PULSE_LEN(1)) u_b (
        .clk(clk), .reset_n_i(rst_n), .intr_signal_i(sig), .intr_mode_i(mode),
        .intr_mask_i(mask), .intr_set_i(set), .intr_clear_i(clr),
        .intr_status_o(st_b), .intr_pending_o(pend_b), .intr_id_o(id_b),
        .bus_intr_o(bus_b));

    intr_ctrl #(.NUM_INTR(16), .PULSE_LEN(15)) u_w (
        .clk(clk), .reset_n_i(rst_w_n), .intr_signal_i(sig_w),
        .intr_mode_i(16'hFFFF), .intr_mask_i(16'hFFFF), .intr_set_i(set_w),
        .intr_clear_i(16'h0000), .intr_status_o(st_w), .intr_pending_o(pend_w),
        .intr_id_o(id_w), .bus_intr_o(bus_w));

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and queue the response expected after the edge.
    task automatic step(input string nm, input logic [3:0] s, input logic [3:0] m,
                        input logic [3:0] st_set, input logic [3:0] c,
                        input logic [3:0] e_st, input logic e_ba, input logic e_bb,
                        input logic e_pend, input logic [1:0] e_id);
        exp_t e;
        @(negedge clk);
        sig  = s;
        mask = m;
        set  = st_set;
        clr  = c;
        e.st = e_st; e.ba = e_ba; e.bb = e_bb; e.pend = e_pend; e.id = e_id;
        sb.push_back(e);
        sb_nm.push_back(nm);
    endtask

    // Monitor: after each active edge, pop one expectation and compare both instances.
    always @(posedge clk) begin
        #2;
        if (sb.size() != 0) begin
            exp_t  e;
            string nm;
            e  = sb.pop_front();
            nm = sb_nm.pop_front();
            check({nm, ".status_a"}, 16'(st_a),   16'(e.st));
            check({nm, ".status_b"}, 16'(st_b),   16'(e.st));
            check({nm, ".bus_a"},    16'(bus_a),  16'(e.ba));
            check({nm, ".bus_b"},    16'(bus_b),  16'(e.bb));
            check({nm, ".pending"},  16'(pend_a), 16'(e.pend));
            check({nm, ".id"},       16'(id_a),   16'(e.id));
            check({nm, ".id_b"},     16'(id_b),   16'(e.id));
        end
    end

    initial begin
        rst_n = 1'b0; rst_w_n = 1'b0;
        sig = '0; mode = '0; mask = '0; set = '0; clr = '0;
        sig_w = '0; set_w = '0;
        #3;
        check("reset.status", 16'(st_a), 16'h0);
        check("reset.bus_a",  16'(bus_a), 16'h0);
        check("reset.bus_b",  16'(bus_b), 16'h0);
        check("reset.pend",   16'(pend_a), 16'h0);
        check("reset.status_w", st_w, 16'h0);
        @(negedge clk); rst_n = 1'b1; rst_w_n = 1'b1;

        // Level mode, single-cycle pulse on channel 1.
        mode = 4'b0000;
        step("idle",      4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 2'd0);
        step("lvl_ch1",   4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 1, 1, 1, 2'd1);
        step("lvl_n2",    4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 1, 0, 1, 2'd1);
        step("lvl_clr",   4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 1, 0, 0, 2'd0);
        step("lvl_done",  4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 2'd0);
        // Simultaneous set and clear: clear wins, no pulse.
        step("setclr",    4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 0, 0, 0, 2'd0);
        // Level held high: relatch after clear.
        step("hold_lat",  4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 1, 1, 2'd0);
        step("hold_keep", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 0, 1, 2'd0);
        step("hold_clr",  4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 1, 0, 0, 2'd0);
        step("hold_relat",4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 1, 1, 2'd0);
        step("hold_drop", 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 1, 0, 0, 2'd0);
        step("hold_t1",   4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 2'd0);
        step("hold_t2",   4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 2'd0);

        // Edge mode ch0, pulse extension by clear then set.
        step("edge_pre",  4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 2'd0);
        mode = 4'b0001;
        step("edge_rise", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 1, 1, 2'd0);
        step("edge_clr",  4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 1, 0, 0, 2'd0);
        step("edge_set",  4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, 1, 1, 2'd0);
        step("ext_n3",    4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 0, 1, 2'd0);
        step("ext_n4",    4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 0, 1, 2'd0);
        step("ext_end",   4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 0, 0, 1, 2'd0);
        step("edge_fin",  4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 0, 0, 0, 2'd0);

        // Edge mode ch3 held high: latch once, no relatch until low-high.
        mode = 4'b1001;
        step("e3_rise",   4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 1, 1, 1, 2'd3);
        step("e3_h1",     4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 1, 0, 1, 2'd3);
        step("e3_h2",     4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 1, 0, 1, 2'd3);
        step("e3_h3",     4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 0, 0, 1, 2'd3);
        step("e3_clr",    4'b1000, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 0, 0, 0, 2'd0);
        step("e3_h5",     4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 2'd0);
        step("e3_h6",     4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 2'd0);
        step("e3_low",    4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 2'd0);
        step("e3_rise2",  4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 1, 1, 1, 2'd3);
        step("e3_clr2",   4'b0000, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 1, 0, 0, 2'd0);
        step("e3_t1",     4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 2'd0);
        step("e3_t2",     4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 2'd0);

        // Masked latch, then unmask: no pulse, pending/id follow mask.
        mode = 4'b0000;
        step("mask_lat",  4'b0000, 4'b0000, 4'b1100, 4'b0000, 4'b1100, 0, 0, 0, 2'd0);
        step("unmask",    4'b0000, 4'b1100, 4'b0000, 4'b0000, 4'b1100, 0, 0, 1, 2'd2);
        step("mask_hi",   4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b1100, 0, 0, 1, 2'd3);
        step("clr_all",   4'b0000, 4'b1100, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0, 2'd0);
        step("prio",      4'b0000, 4'b1111, 4'b1010, 4'b0000, 4'b1010, 1, 1, 1, 2'd1);
        step("prio_clr",  4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 1, 0, 0, 2'd0);
        step("prio_t1",   4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 2'd0);
        step("prio_t2",   4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 2'd0);
        repeat (3) @(negedge clk);
        check("sb_drained", 16'(sb.size()), 16'h0);

        // 16-channel, 15-clock pulse: reset mid-pulse drops everything at once.
        @(negedge clk); set_w = 16'h0020;
        @(negedge clk); set_w = 16'h0000;
        check("w.bus_start", 16'(bus_w), 16'h1);
        repeat (8) @(negedge clk);
        check("w.bus_mid",    16'(bus_w), 16'h1);
        check("w.status_mid", st_w, 16'h0020);
        check("w.id_mid",     16'(id_w), 16'h5);
        #2 rst_w_n = 1'b0;
        #1;
        check("w.rst_bus",    16'(bus_w), 16'h0);
        check("w.rst_status", st_w, 16'h0);
        check("w.rst_pend",   16'(pend_w), 16'h0);
        repeat (2) @(negedge clk);
        rst_w_n = 1'b1;
        repeat (20) @(negedge clk);
        check("w.post_bus",    16'(bus_w), 16'h0);
        check("w.post_status", st_w, 16'h0);
        check("w.post_pend",   16'(pend_w), 16'h0);
        check("w.post_id",     16'(id_w), 16'h0);

        // Edge input already high at reset release counts as a rising edge.
        rst_w_n = 1'b0;
        sig_w   = 16'h0004;
        @(negedge clk); rst_w_n = 1'b1;
        @(negedge clk);
        check("w.rel_status", st_w, 16'h0004);
        check("w.rel_bus",    16'(bus_w), 16'h1);
        check("w.rel_id",     16'(id_w), 16'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 SHALL have parameter NUM_INTR, default 4, number of interrupt channels (legal 1..16).
REQ-002 SHALL have parameter PULSE_LEN, default 1, bus_intr_o high time in clocks per trigger (legal 1..15).
REQ-003 SHALL derive localparam ID_W = max(1, clog2(NUM_INTR)).
REQ-004 SHALL use one clock, clk; reset is asynchronous and active-low, port reset_n_i.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset_n_i  in  1  async active-low reset.
REQ-007 intr_signal_i  in  NUM_INTR  per-channel request from sources (video_gen, copper, blitter).
REQ-008 intr_mode_i  in  NUM_INTR  per channel: 1 = rising-edge detect, 0 = level.
REQ-009 intr_mask_i  in  NUM_INTR  per channel: 1 = enabled for bus_intr_o.
REQ-010 intr_set_i  in  NUM_INTR  CPU software-set strobe.
REQ-011 intr_clear_i  in  NUM_INTR  CPU clear strobe.
REQ-012 intr_status_o  out  NUM_INTR  latched pending status (registered).
REQ-013 intr_pending_o  out  1  OR of (intr_status_o & intr_mask_i).
REQ-014 intr_id_o  out  ID_W  lowest-numbered channel set in (intr_status_o & intr_mask_i); 0 if none.
REQ-015 bus_intr_o  out  1  CPU interrupt pulse (registered).

Function
REQ-016 SHALL keep sig_prev, one registered copy of intr_signal_i.
REQ-017 Per channel n, event[n] SHALL be intr_signal_i[n] & ~sig_prev[n] when intr_mode_i[n]=1, else intr_signal_i[n].
REQ-018 req = event | intr_set_i.
REQ-019 Each clock, status SHALL become (status | req) & ~intr_clear_i: clear wins over a simultaneous event/set on the same channel.
REQ-020 trig SHALL be nonzero when any channel has req & intr_mask_i & ~status & ~intr_clear_i, with status taken before update.
REQ-021 Event at cycle N SHALL appear on intr_status_o and bus_intr_o at cycle N+1: 1-clock latency.
REQ-022 Pulse counter (4 bits): on trig, load PULSE_LEN; else decrement if nonzero. bus_intr_o is high while counter nonzero.
REQ-023 Retrigger while the pulse is active SHALL reload PULSE_LEN and extend the pulse, with no low gap.
REQ-024 Level-mode channel held high SHALL re-latch status on the cycle after a clear, but SHALL NOT retrigger while status stays set.
REQ-025 Edge-mode channel held high SHALL latch once and not re-latch after clear until the signal goes low then high.
REQ-026 Unmasking a channel whose status is already set SHALL NOT trigger bus_intr_o. It SHALL affect only intr_pending_o and intr_id_o, combinationally.
REQ-027 Masked channels SHALL still latch status.
REQ-028 intr_pending_o and intr_id_o SHALL be combinational from registered status and intr_mask_i.
REQ-029 With NUM_INTR=4, PULSE_LEN=1, behaviour SHALL equal the existing 4-channel level interrupt logic: status, clear precedence, and 1-cycle bus_intr_o.

Reset
REQ-030 While reset_n_i=0, and asynchronously on assertion: intr_status_o=0, sig_prev=0, pulse counter=0, bus_intr_o=0.
REQ-031 On the first edge after deassertion, an edge-mode input already high SHALL count as a rising edge, because sig_prev=0.
REQ-032 Reset asserted mid-pulse SHALL drop bus_intr_o immediately with no completion.

Verification
REQ-033 NUM_INTR=4, PULSE_LEN=1, mask=4'b0010, level mode: 1-clk pulse on signal[1] -> status=4'b0010 and bus_intr_o=1 at N+1, bus_intr_o=0 at N+2, id=1, pending=1.
REQ-034 PULSE_LEN=3, edge mode ch0 masked: rising edge at N -> bus_intr_o high N+1..N+3; clear ch0 plus new set at N+2 -> pulse extends to N+5.
REQ-035 Simultaneous set[2] and clear[2] with status[2]=0 -> status[2] stays 0 and no bus_intr_o.
REQ-036 Status 4'b1100 set while mask=0, then mask=4'b1100 -> bus_intr_o stays 0, pending=1, id=2.
REQ-037 Edge mode ch3 held high 10 clks, clear at clk 5 -> status[3] latches once; after clear stays 0 until low then high.
REQ-038 NUM_INTR=16, PULSE_LEN=15: reset_n_i low at pulse count 7 -> bus_intr_o and status go 0 asynchronously; after release all outputs stay 0 with no stimulus.
